// File: rtl/panda_top_bench.sv
// panda_top_bench: position-capture DMA and interrupt engine.
// Samples are queued in a 16-deep FIFO and written out as word writes into
// buffers taken from a circular DMA address table. A level interrupt is raised
// from the IRQ_STATUS flags, with FRAMING_MASK selecting which flags count.
// Optional feature macro: PCAP_TIMEOUT_EN (partial-block close on idle timeout).
module panda_top_bench #(
  parameter int unsigned BLK_WORDS_W = 16,
  parameter int unsigned TBL_DEPTH   = 32
) (
  input  logic        FCLK,
  input  logic        tb_ARESETn,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdat,
  output logic [31:0] reg_rdat,
  input  logic        smpl_valid,
  input  logic [31:0] smpl_data,
  output logic        dma_valid,
  output logic [31:0] dma_addr,
  output logic [31:0] dma_data,
  input  logic        dma_ready,
  output logic        irq
);

  localparam int unsigned TBL_AW     = $clog2(TBL_DEPTH);
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_AW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state, next_state;

  // Configuration registers
  logic [31:0] blk_reg;
  logic [31:0] timeout_reg;
  logic [31:0] mask_reg;

  // Status
  logic [7:0]             flags;
  logic [7:0]             ev;
  logic [BLK_WORDS_W-1:0] smpl_count;

  // Current buffer
  logic [31:0]            base;
  logic [BLK_WORDS_W-1:0] offset;
  logic [BLK_WORDS_W:0]   offset_inc;
  logic [BLK_WORDS_W-1:0] blk_eff;

  // Address table (word addresses, bits[1:0] dropped)
  logic [29:0]       tbl_mem [TBL_DEPTH];
  logic [TBL_AW-1:0] tbl_wr_ptr, tbl_rd_ptr;
  logic [TBL_AW:0]   tbl_count;
  logic              tbl_empty, tbl_full, tbl_push, tbl_pop;

  // Sample FIFO
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] fifo_wr_ptr, fifo_rd_ptr;
  logic [FIFO_AW:0]   fifo_count;
  logic               fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_flush;

  // Control
  logic wr_arm, wr_disarm, wr_tbl, wr_blk, wr_tmo, wr_mask, wr_tbl_rst, rd_status;
  logic xfer, blk_end, tmo_end, load_base;

  assign wr_arm     = reg_wr && (reg_addr == 3'd0);
  assign wr_disarm  = reg_wr && (reg_addr == 3'd1);
  assign wr_tbl     = reg_wr && (reg_addr == 3'd2);
  assign wr_blk     = reg_wr && (reg_addr == 3'd3);
  assign wr_tmo     = reg_wr && (reg_addr == 3'd4);
  assign wr_mask    = reg_wr && (reg_addr == 3'd6);
  assign wr_tbl_rst = reg_wr && (reg_addr == 3'd7);
  assign rd_status  = reg_rd && (reg_addr == 3'd5);

  assign tbl_empty  = (tbl_count == '0);
  assign tbl_full   = (tbl_count == (TBL_AW+1)'(TBL_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (FIFO_AW+1)'(FIFO_DEPTH));

  assign dma_valid = !fifo_empty;
  assign dma_data  = dma_valid ? fifo_mem[fifo_rd_ptr] : '0;
  assign dma_addr  = dma_valid ? (base + 32'({offset, 2'b00})) : '0;
  assign xfer      = dma_valid && dma_ready;

  assign blk_eff    = (blk_reg[BLK_WORDS_W-1:0] == '0) ? BLK_WORDS_W'(1)
                                                       : blk_reg[BLK_WORDS_W-1:0];
  assign offset_inc = {1'b0, offset} + (BLK_WORDS_W+1)'(1);
  assign blk_end    = xfer && (offset_inc >= {1'b0, blk_eff});

`ifdef PCAP_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Close the partial block only when no write is pending, so a stalled
  // request keeps its address.
  assign tmo_end = (state == ST_ARMED) && (timeout_reg != '0) &&
                   (tmo_cnt >= timeout_reg) && (offset != '0) && fifo_empty;

  // Idle counter, cleared by every transfer
  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) begin
      tmo_cnt <= '0;
    end else if ((state != ST_ARMED) || (timeout_reg == '0) || xfer || tmo_end) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt < timeout_reg) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  assign tmo_end = 1'b0;
`endif

  // State register
  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) state <= ST_IDLE;
    else             state <= next_state;
  end

  // Next state, table pop / base reload and flag events
  always_comb begin
    next_state = state;
    tbl_pop    = 1'b0;
    load_base  = 1'b0;
    fifo_flush = 1'b0;
    ev         = '0;
    ev[4]      = smpl_valid && (state == ST_ARMED) && fifo_full;
    case (state)
      ST_IDLE: begin
        if (wr_arm) begin
          if (!tbl_empty) begin
            next_state = ST_ARMED;
            tbl_pop    = 1'b1;
            load_base  = 1'b1;
          end else begin
            ev[2] = 1'b1;
          end
        end
      end
      ST_ARMED, ST_DRAIN: begin
        if (blk_end || tmo_end) begin
          ev[0] = 1'b1;
          ev[3] = tmo_end;
          if (!tbl_empty) begin
            tbl_pop   = 1'b1;
            load_base = 1'b1;
          end else begin
            ev[2]      = 1'b1;
            fifo_flush = 1'b1;
            next_state = ST_IDLE;
          end
        end
        if (next_state != ST_IDLE) begin
          if ((state == ST_ARMED) && wr_disarm) begin
            next_state = ST_DRAIN;
          end else if ((state == ST_DRAIN) && fifo_empty) begin
            ev[1]      = 1'b1;
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
    tbl_push = wr_tbl && !wr_tbl_rst && (!tbl_full || tbl_pop);
    ev[5]    = wr_tbl && !wr_tbl_rst && tbl_full && !tbl_pop;
  end

  assign fifo_push = smpl_valid && (state == ST_ARMED) && !fifo_full && !fifo_flush;
  assign fifo_pop  = xfer && !fifo_flush;

  // Table pointers and fill level
  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) begin
      tbl_wr_ptr <= '0;
      tbl_rd_ptr <= '0;
      tbl_count  <= '0;
    end else if (wr_tbl_rst) begin
      tbl_wr_ptr <= '0;
      tbl_rd_ptr <= '0;
      tbl_count  <= '0;
    end else begin
      if (tbl_push)
        tbl_wr_ptr <= (tbl_wr_ptr == TBL_AW'(TBL_DEPTH-1)) ? '0 : tbl_wr_ptr + TBL_AW'(1);
      if (tbl_pop)
        tbl_rd_ptr <= (tbl_rd_ptr == TBL_AW'(TBL_DEPTH-1)) ? '0 : tbl_rd_ptr + TBL_AW'(1);
      case ({tbl_push, tbl_pop})
        2'b10:   tbl_count <= tbl_count + (TBL_AW+1)'(1);
        2'b01:   tbl_count <= tbl_count - (TBL_AW+1)'(1);
        default: tbl_count <= tbl_count;
      endcase
    end
  end

  // Table storage
  always_ff @(posedge FCLK) begin
    if (tbl_push) tbl_mem[tbl_wr_ptr] <= reg_wdat[31:2];
  end

  // FIFO pointers and fill level
  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else if (fifo_flush) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else begin
      if (fifo_push) fifo_wr_ptr <= fifo_wr_ptr + FIFO_AW'(1);
      if (fifo_pop)  fifo_rd_ptr <= fifo_rd_ptr + FIFO_AW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge FCLK) begin
    if (fifo_push) fifo_mem[fifo_wr_ptr] <= smpl_data;
  end

  // Buffer base and word offset
  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) begin
      base   <= '0;
      offset <= '0;
    end else if (load_base) begin
      base   <= {tbl_mem[tbl_rd_ptr], 2'b00};
      offset <= '0;
    end else if (xfer) begin
      offset <= offset_inc[BLK_WORDS_W-1:0];
    end
  end

  // Flags and sample count; a status read clears but keeps same-cycle events
  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) begin
      flags      <= '0;
      smpl_count <= '0;
    end else if (rd_status) begin
      flags      <= ev;
      smpl_count <= xfer ? BLK_WORDS_W'(1) : '0;
    end else begin
      flags <= flags | ev;
      if (xfer && (smpl_count != '1)) smpl_count <= smpl_count + BLK_WORDS_W'(1);
    end
  end

  // Writable configuration registers
  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) begin
      blk_reg     <= 32'd1;
      timeout_reg <= '0;
      mask_reg    <= '0;
    end else begin
      if (wr_blk)  blk_reg     <= reg_wdat;
      if (wr_tmo)  timeout_reg <= reg_wdat;
      if (wr_mask) mask_reg    <= reg_wdat;
    end
  end

  // Registered read data
  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) begin
      reg_rdat <= '0;
    end else if (reg_rd) begin
      case (reg_addr)
        3'd2:    reg_rdat <= 32'(tbl_count);
        3'd3:    reg_rdat <= blk_reg;
        3'd4:    reg_rdat <= timeout_reg;
        3'd5:    reg_rdat <= {16'(smpl_count), 8'h00, flags};
        3'd6:    reg_rdat <= mask_reg;
        default: reg_rdat <= '0;
      endcase
    end
  end

  // Level interrupt from unmasked flags
  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) irq <= 1'b0;
    else             irq <= |(flags & ~mask_reg[7:0]);
  end

endmodule

// File: tb/tb_panda_top_bench.sv
// Directed bench for panda_top_bench; expected values are hand-computed.
// Define PCAP_TIMEOUT_EN for both files to also exercise the timeout close.
module tb_panda_top_bench;

  logic        FCLK = 1'b0;
  logic        tb_ARESETn;
  logic        reg_wr, reg_rd;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdat, reg_rdat;
  logic        smpl_valid;
  logic [31:0] smpl_data;
  logic        dma_valid, dma_ready, irq;
  logic [31:0] dma_addr, dma_data;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd;
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];

  panda_top_bench #(.BLK_WORDS_W(16), .TBL_DEPTH(32)) dut (
    .FCLK(FCLK), .tb_ARESETn(tb_ARESETn),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdat(reg_wdat), .reg_rdat(reg_rdat),
    .smpl_valid(smpl_valid), .smpl_data(smpl_data),
    .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_data(dma_data),
    .dma_ready(dma_ready), .irq(irq)
  );

  always #5 FCLK = ~FCLK;

  // Record every accepted write; the handshake completes on the next posedge
  always @(negedge FCLK) begin
    if (tb_ARESETn && dma_valid && dma_ready) begin
      mon_addr.push_back(dma_addr);
      mon_data.push_back(dma_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge FCLK);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdat = d;
    tick(1);
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    tick(1);
    reg_rd = 1'b0;
    d = reg_rdat;
  endtask

  task automatic send_samples(input int n, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      smpl_valid = 1'b1;
      smpl_data  = first + 32'(i);
      tick(1);
    end
    smpl_valid = 1'b0;
  endtask

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tb_ARESETn = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdat = '0;
    smpl_valid = 1'b0; smpl_data = '0; dma_ready = 1'b0;
    tick(4);
    tb_ARESETn = 1'b1;
    tick(1);

    // Reset state
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_dma_valid", 32'(dma_valid), 32'd0);
    reg_read(3'd5, rd); check_val("rst_status", rd, 32'h0000_0000);
    reg_read(3'd2, rd); check_val("rst_tbl_level", rd, 32'd0);
    reg_read(3'd3, rd); check_val("rst_blk_size", rd, 32'd1);

    // One full block of 4, then the second entry becomes the base
    reg_write(3'd2, 32'h0000_1000);
    reg_write(3'd2, 32'h0000_2000);
    reg_write(3'd3, 32'd4);
    reg_read(3'd2, rd); check_val("blk_tbl_level", rd, 32'd2);
    dma_ready = 1'b1;
    clear_mon();
    reg_write(3'd0, 32'd0);
    send_samples(4, 32'h0000_00A0);
    tick(6);
    check_val("blk_nwrites", 32'(mon_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("blk_addr", mon_addr[i], 32'h0000_1000 + 32'(4 * i));
      check_val("blk_data", mon_data[i], 32'h0000_00A0 + 32'(i));
    end
    check_val("blk_irq", 32'(irq), 32'd1);
    reg_read(3'd5, rd); check_val("blk_status", rd, 32'h0004_0001);
    reg_read(3'd5, rd); check_val("blk_status_2nd", rd, 32'h0000_0000);
    reg_read(3'd2, rd); check_val("blk_tbl_after", rd, 32'd0);
    reg_write(3'd1, 32'd0);
    tick(3);
    reg_read(3'd5, rd); check_val("blk_disarm_status", rd, 32'h0000_0002);
    tick(2);
    check_val("blk_irq_clr", 32'(irq), 32'd0);

    // ARM with empty table
    reg_write(3'd0, 32'd0);
    tick(2);
    check_val("aerr_irq", 32'(irq), 32'd1);
    reg_read(3'd5, rd); check_val("aerr_status", rd, 32'h0000_0004);
    tick(2);
    check_val("aerr_irq_clr", 32'(irq), 32'd0);

    // Partial block ended by DISARM
    reg_write(3'd2, 32'h0000_1000);
    reg_write(3'd3, 32'd8);
    clear_mon();
    reg_write(3'd0, 32'd0);
    send_samples(3, 32'h0000_00B0);
    reg_write(3'd1, 32'd0);
    tick(8);
    check_val("dis_nwrites", 32'(mon_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_val("dis_addr", mon_addr[i], 32'h0000_1000 + 32'(4 * i));
      check_val("dis_data", mon_data[i], 32'h0000_00B0 + 32'(i));
    end
    reg_read(3'd5, rd); check_val("dis_status", rd, 32'h0003_0002);
    clear_mon();
    send_samples(1, 32'h0000_0BAD);
    tick(4);
    check_val("dis_idle_nwrites", 32'(mon_addr.size()), 32'd0);
    check_val("dis_idle_valid", 32'(dma_valid), 32'd0);

    // Stall with FIFO overrun, stable request, irq masking, drain
    reg_write(3'd2, 32'h0000_3000);
    reg_write(3'd3, 32'd32);
    dma_ready = 1'b0;
    clear_mon();
    reg_write(3'd0, 32'd0);
    send_samples(20, 32'h0000_0C00);
    tick(1);
    check_val("ovr_valid", 32'(dma_valid), 32'd1);
    check_val("ovr_addr", dma_addr, 32'h0000_3000);
    check_val("ovr_data", dma_data, 32'h0000_0C00);
    tick(5);
    check_val("ovr_addr_hold", dma_addr, 32'h0000_3000);
    check_val("ovr_data_hold", dma_data, 32'h0000_0C00);
    check_val("ovr_irq", 32'(irq), 32'd1);
    reg_write(3'd6, 32'h0000_0010);
    tick(2);
    check_val("ovr_irq_masked", 32'(irq), 32'd0);
    reg_write(3'd1, 32'd0);
    dma_ready = 1'b1;
    tick(25);
    check_val("ovr_nwrites", 32'(mon_addr.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check_val("ovr_drain_addr", mon_addr[i], 32'h0000_3000 + 32'(4 * i));
      check_val("ovr_drain_data", mon_data[i], 32'h0000_0C00 + 32'(i));
    end
    reg_read(3'd5, rd); check_val("ovr_status", rd, 32'h0010_0012);
    reg_read(3'd6, rd); check_val("mask_readback", rd, 32'h0000_0010);
    reg_write(3'd6, 32'd0);
    tick(2);
    check_val("ovr_irq_clr", 32'(irq), 32'd0);

    // BLOCK_SIZE 0 behaves as 1; second completion finds the table empty
    reg_write(3'd3, 32'd0);
    reg_write(3'd2, 32'h0000_6000);
    reg_write(3'd2, 32'h0000_7003);
    clear_mon();
    reg_write(3'd0, 32'd0);
    send_samples(2, 32'h0000_00D0);
    tick(6);
    check_val("bs0_nwrites", 32'(mon_addr.size()), 32'd2);
    check_val("bs0_addr0", mon_addr[0], 32'h0000_6000);
    check_val("bs0_addr1", mon_addr[1], 32'h0000_7000);
    reg_read(3'd5, rd); check_val("bs0_status", rd, 32'h0002_0005);
    reg_read(3'd3, rd); check_val("bs0_readback", rd, 32'd0);

    // Table overflow and TABLE_RESET
    reg_write(3'd7, 32'd0);
    for (int i = 0; i < 33; i++) reg_write(3'd2, 32'h0001_0000 + 32'(i * 256));
    reg_read(3'd2, rd); check_val("tfull_level", rd, 32'd32);
    reg_read(3'd5, rd); check_val("tfull_status", rd, 32'h0000_0020);
    reg_write(3'd7, 32'd0);
    reg_read(3'd2, rd); check_val("trst_level", rd, 32'd0);
    reg_write(3'd2, 32'h0000_8000);
    clear_mon();
    reg_write(3'd0, 32'd0);
    send_samples(1, 32'h0000_00E5);
    tick(5);
    check_val("trst_nwrites", 32'(mon_addr.size()), 32'd1);
    check_val("trst_addr", mon_addr[0], 32'h0000_8000);
    reg_read(3'd5, rd); check_val("trst_status", rd, 32'h0001_0005);

    // Register read-back of write-only and plain registers
    reg_read(3'd0, rd); check_val("idx0_read", rd, 32'd0);
    reg_read(3'd7, rd); check_val("idx7_read", rd, 32'd0);
    reg_write(3'd4, 32'h0000_1234);
    reg_read(3'd4, rd); check_val("tmo_readback", rd, 32'h0000_1234);

`ifdef PCAP_TIMEOUT_EN
    // Idle timeout closes a partial block and moves to the next entry
    reg_write(3'd4, 32'd100);
    reg_write(3'd3, 32'd8);
    reg_write(3'd2, 32'h0000_4000);
    reg_write(3'd2, 32'h0000_5000);
    clear_mon();
    reg_write(3'd0, 32'd0);
    send_samples(2, 32'h0000_00F0);
    tick(120);
    check_val("tmo_nwrites", 32'(mon_addr.size()), 32'd2);
    reg_read(3'd5, rd); check_val("tmo_status", rd, 32'h0002_0009);
    clear_mon();
    send_samples(1, 32'h0000_00F8);
    tick(4);
    check_val("tmo_next_addr", mon_addr[0], 32'h0000_5000);
    reg_write(3'd1, 32'd0);
    tick(4);
    reg_read(3'd5, rd); check_val("tmo_disarm_status", rd, 32'h0001_0002);
    reg_write(3'd4, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
